// File: rtl/sequential_divider_taint_track.sv
// Purpose : constant-time restoring divider (quotient, remainder) with word-level taint tracking.
// Latency : start accepted at edge 1; quotient/remainder/done update at edge NUM_BITS+1; back to IDLE one edge later.
// Backpres: none; start is only sampled in IDLE and is dropped (not queued) while busy. Optional: DIV_ZERO_FLAG_EN adds div_zero/div_zero_t.
module sequential_divider_taint_track #(
    parameter int NUM_BITS = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_BITS-1:0] dividend,
    input  logic [NUM_BITS-1:0] divisor,
    input  logic                start_t,
    input  logic                dividend_t,
    input  logic                divisor_t,
    output logic [NUM_BITS-1:0] quotient,
    output logic [NUM_BITS-1:0] remainder,
    output logic                busy,
    output logic                done,
    output logic                quotient_t,
    output logic                remainder_t,
    output logic                busy_t,
`ifdef DIV_ZERO_FLAG_EN
    output logic                done_t,
    output logic                div_zero,
    output logic                div_zero_t
`else
    output logic                done_t
`endif
);

    localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_BITS-1:0] work;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [NUM_BITS-1:0] dvsr;
    logic [NUM_BITS:0]   rem_acc;    // one bit wider than the operands so the compare cannot overflow

    logic [NUM_BITS:0]   rem_shift;
    logic [NUM_BITS:0]   rem_diff;
    logic [NUM_BITS:0]   rem_next;
    logic                q_bit;
    logic [NUM_BITS-1:0] work_next;

    logic                op_t;
    logic                dvs_t;
    logic                state_t;

    // One restoring step; the same compare/subtract/mux is evaluated every cycle regardless of data.
    always_comb begin
        rem_shift = (rem_acc << 1) | {{NUM_BITS{1'b0}}, work[NUM_BITS-1]};
        rem_diff  = rem_shift - {1'b0, dvsr};
        q_bit     = (rem_shift >= {1'b0, dvsr});
        rem_next  = q_bit ? rem_diff : rem_shift;
        work_next = {work[NUM_BITS-2:0], q_bit};
    end

    // Control FSM with registered datapath and outputs; fixed NUM_BITS iterations, no early exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            dvsr      <= '0;
            rem_acc   <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work    <= dividend;
                        dvsr    <= divisor;
                        rem_acc <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    rem_acc <= rem_next;
                    work    <= work_next;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_BITS - 1)) begin
                        quotient  <= work_next;
                        remainder <= rem_next[NUM_BITS-1:0];
                        done      <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero  <= (dvsr == '0);
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Taint state: operand taint follows each accepted op; control taint is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_t    <= 1'b0;
            dvs_t   <= 1'b0;
            state_t <= 1'b0;
        end else if (state == IDLE) begin
            if (start_t) begin
                state_t <= 1'b1;
            end
            if (start) begin
                op_t  <= dividend_t | divisor_t;
                dvs_t <= divisor_t;
            end
        end
    end

    // Output taint: data taint reaches only the results, timing outputs see only control taint.
    always_comb begin
        quotient_t  = op_t | state_t;
        remainder_t = op_t | state_t;
        busy_t      = state_t;
        done_t      = state_t;
`ifdef DIV_ZERO_FLAG_EN
        div_zero_t  = dvs_t | state_t;
`endif
    end

`ifndef DIV_ZERO_FLAG_EN
    // Latched divisor taint only feeds the optional flag; keep it referenced in the default build.
    logic unused_dvs_t;
    assign unused_dvs_t = dvs_t;
`endif

endmodule

// File: tb/tb_sequential_divider_taint_track.sv
// Purpose : randomized + directed scoreboard bench for sequential_divider_taint_track.
// Latency : expects done visible after edge NUM_BITS+1 counting the accept edge as edge 1.
// Backpres: driver waits for each op to retire; monitor pops the scoreboard on every done.
module tb_sequential_divider_taint_track;

    localparam int NB = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NB-1:0] dividend = '0;
    logic [NB-1:0] divisor = '0;
    logic          start_t = 1'b0;
    logic          dividend_t = 1'b0;
    logic          divisor_t = 1'b0;
    logic [NB-1:0] quotient;
    logic [NB-1:0] remainder;
    logic          busy, done, quotient_t, remainder_t, busy_t, done_t;
`ifdef DIV_ZERO_FLAG_EN
    logic          div_zero, div_zero_t;
`endif

    sequential_divider_taint_track #(.NUM_BITS(NB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .start_t     (start_t),
        .dividend_t  (dividend_t),
        .divisor_t   (divisor_t),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .quotient_t  (quotient_t),
        .remainder_t (remainder_t),
        .busy_t      (busy_t),
`ifdef DIV_ZERO_FLAG_EN
        .done_t      (done_t),
        .div_zero    (div_zero),
        .div_zero_t  (div_zero_t)
`else
        .done_t      (done_t)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        bit qt;
        bit st;
        bit dz;
        bit dzt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   st_model = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse retires the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient",    quotient,    e.q);
                    check("remainder",   remainder,   e.r);
                    check("quotient_t",  quotient_t,  e.qt);
                    check("remainder_t", remainder_t, e.qt);
                    check("done_t",      done_t,      e.st);
                    check("busy_t",      busy_t,      e.st);
`ifdef DIV_ZERO_FLAG_EN
                    check("div_zero",    div_zero,    e.dz);
                    check("div_zero_t",  div_zero_t,  e.dzt);
`endif
                end
            end
        end
    end

    // Issue one division, push its expected result, and check latency/pulse/hold.
    task automatic do_op(input int a, input int b, input bit at, input bit bt,
                         input bit sat, input bit glitch);
        exp_t e;
        int   lat;
        @(negedge clk);
        st_model = st_model | sat;
        e.q   = (b == 0) ? (1 << NB) - 1 : a / b;
        e.r   = (b == 0) ? a : a % b;
        e.qt  = at | bt | st_model;
        e.st  = st_model;
        e.dz  = (b == 0);
        e.dzt = bt | st_model;
        sb.push_back(e);
        dividend   = NB'(a);
        divisor    = NB'(b);
        dividend_t = at;
        divisor_t  = bt;
        start_t    = sat;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        start_t    = 1'b0;
        dividend_t = 1'b0;
        divisor_t  = 1'b0;
        dividend   = NB'($urandom);
        divisor    = NB'($urandom);
        lat = 1;
        check("busy_after_accept", busy, 1);
        while (done !== 1'b1 && lat < 20) begin
            if (glitch && lat == 3) begin
                start    = 1'b1;
                dividend = NB'($urandom);
                divisor  = NB'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, NB + 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("quotient_hold", quotient, e.q);
        check("remainder_hold", remainder, e.r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b;
        // Reset values
        #12;
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_taint", {quotient_t, remainder_t, busy_t, done_t}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operand patterns
        do_op(100, 7, 0, 0, 0, 0);
        do_op(12, 0, 0, 0, 0, 0);
        do_op(0, 5, 0, 0, 0, 0);
        do_op(127, 1, 0, 0, 0, 0);
        // start during ITER must be ignored
        do_op(99, 10, 0, 0, 0, 1);
        check("no_restart_busy", busy, 0);
        // Data taint alone
        do_op(92, 75, 1, 0, 0, 0);
        // Control taint without start, then sticky on later ops
        @(negedge clk);
        start_t = 1'b1;
        @(negedge clk);
        start_t  = 1'b0;
        st_model = 1'b1;
        check("busy_t_sticky", busy_t, 1);
        check("no_start_busy", busy, 0);
        do_op(50, 6, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, 127);
            b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
            do_op(a, b, 1'($urandom), 1'($urandom), 0, 0);
        end

        // Reset mid-ITER aborts and clears everything asynchronously
        @(negedge clk);
        dividend = 7'd100;
        divisor  = 7'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_quotient", quotient, 0);
        check("arst_remainder", remainder, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_taint", {quotient_t, remainder_t, busy_t, done_t}, 0);
        st_model = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(42, 5, 0, 0, 0, 0);

        // Randomized, untainted control
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(0, 127);
            b = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 127);
            do_op(a, b, 1'($urandom), 1'($urandom), 0, 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
